bin_to_bcd_seq: RTL and testbench

Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) that turns a 16-bit unsigned binary result into four packed BCD digits for the `led` 7-segment decoders and `LED_MUX`. It replaces fixed-value BCD lookup with a general conversion of any value 0–9999. Values 10000–65535 are flagged and saturated. A start/busy/done handshake lets the upstream computation stage launch a conversion whenever its result is ready.

---
 rtl/bin_to_bcd_seq.sv | 111 +++++++++++
 tb/tb_bin_to_bcd_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential 16-bit binary to 4-digit packed BCD converter.
// Shift-and-add-3, one bit per clock, saturates above 9999.
module bin_to_bcd_seq (
  input  logic        clk50MHz,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd,
  output logic        overflow
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] sr_q, sr_d;
  logic [19:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] bcd_q, bcd_d;
  logic        ovf_q, ovf_d;

  logic [19:0] adj;
  logic [19:0] acc_sh;

  // Digit-local add-3 on every scratch digit that is 5 or more.
  always_comb begin
    adj = acc_q;
    for (int i = 0; i < 5; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  // Scratch after this cycle's shift; MSB of sr enters at bit 0.
  assign acc_sh = {adj[18:0], sr_q[15]};

  // Next-state and datapath update for the IDLE/SHIFT machine.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = bin;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d = acc_sh;
        sr_d  = {sr_q[14:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
          if (acc_sh[19:16] != 4'd0) begin
            bcd_d = 16'h9999;
            ovf_d = 1'b1;
          end else begin
            bcd_d = acc_sh[15:0];
            ovf_d = 1'b0;
          end
        end
      end
    endcase
  end

  // State registers with synchronous reset that aborts any conversion.
  always_ff @(posedge clk50MHz) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq.
// Expected values are hand-computed BCD constants.
module tb_bin_to_bcd_seq;

  logic        clk50MHz = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] bin;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic        overflow;

  int ntests = 0;
  int nfail  = 0;

  bin_to_bcd_seq dut (
    .clk50MHz (clk50MHz),
    .rst      (rst),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .overflow (overflow)
  );

  always #10 clk50MHz = ~clk50MHz;

  task automatic tick;
    @(posedge clk50MHz);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Launch one conversion and wait (bounded) for done.
  task automatic conv(input logic [15:0] v,
                      output int lat,
                      output int bcnt);
    bin   = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    bcnt  = int'(busy);
    lat   = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      lat++;
      if (done) break;
      bcnt += int'(busy);
    end
  endtask

  int lat, bcnt, ndone;
  logic [15:0] seen;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bcd", bcd, 16'h0000);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;
    tick();

    conv(16'd5040, lat, bcnt);
    chk("5040_lat", lat, 16);
    chk("5040_busy_cycles", bcnt, 16);
    chk("5040_bcd", bcd, 16'h5040);
    chk("5040_ovf", overflow, 0);
    chk("5040_busy_at_done", busy, 0);
    tick();
    chk("5040_done_one_cycle", done, 0);
    chk("5040_bcd_hold", bcd, 16'h5040);

    conv(16'd0, lat, bcnt);
    chk("0_bcd", bcd, 16'h0000);
    chk("0_ovf", overflow, 0);
    conv(16'd9999, lat, bcnt);
    chk("9999_bcd", bcd, 16'h9999);
    chk("9999_ovf", overflow, 0);

    conv(16'd10000, lat, bcnt);
    chk("10000_bcd", bcd, 16'h9999);
    chk("10000_ovf", overflow, 1);
    conv(16'd65535, lat, bcnt);
    chk("65535_bcd", bcd, 16'h9999);
    chk("65535_ovf", overflow, 1);
    conv(16'd720, lat, bcnt);
    chk("720_bcd", bcd, 16'h0720);
    chk("720_ovf", overflow, 0);
    tick();

    // start during SHIFT must be ignored
    bin   = 16'd1234;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    bin   = 16'd4321;
    start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    seen  = '0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (done) begin
        ndone++;
        seen = bcd;
      end
    end
    chk("ign_done_count", ndone, 1);
    chk("ign_bcd", seen, 16'h1234);
    chk("ign_idle", busy, 0);

    // start held high, bin alternates per accepted conversion
    bin   = 16'd24;
    start = 1'b1;
    tick();
    bin = 16'd120;
    for (int i = 0; i < 4; i++) begin
      lat = 0;
      for (int k = 0; k < 40; k++) begin
        tick();
        lat++;
        if (done) break;
      end
      chk($sformatf("bb_lat%0d", i), lat, 16);
      chk($sformatf("bb_bcd%0d", i), bcd,
          (i % 2 == 0) ? 16'h0024 : 16'h0120);
      if (i == 3) start = 1'b0;
      tick();
      chk($sformatf("bb_done_low%0d", i), done, 0);
      chk($sformatf("bb_busy%0d", i), busy,
          (i == 3) ? 0 : 1);
      bin = (bin == 16'd24) ? 16'd120 : 16'd24;
    end

    // reset aborts a conversion in progress
    bin   = 16'd5040;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_bcd", bcd, 16'h0000);
    chk("abort_ovf", overflow, 0);
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    conv(16'd5040, lat, bcnt);
    chk("post_rst_lat", lat, 16);
    chk("post_rst_bcd", bcd, 16'h5040);
    chk("post_rst_ovf", overflow, 0);

    $display("[TB] %0d tests run, %0d failed",
             ntests, nfail);
    $finish;
  end

endmodule
